imem_lockstep_arbiter: RTL and testbench

//  Shares the single-port, 1-cycle-latency instruction memory between core 0 and core 1 fetch ports.

---
 rtl/imem_lockstep_arbiter.sv | 164 ++++++++++++++++
 tb/tb_imem_lockstep_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_lockstep_arbiter.sv
// imem_lockstep_arbiter: lets core 0 and core 1 fetch ports share one
// single-port instruction memory that has a one-cycle read latency.
//   Lockstep mode: both cores must fetch the same address in the same cycle.
//     One read serves both cores; any divergence or timeout sets a sticky error.
//   Split mode: requests are granted one per cycle in round-robin order.
// Ports:
//   clock, reset_n         clock, asynchronous active-low reset
//   lockstep_en            1 = lockstep mode, 0 = split mode
//   err_clr                pulse that clears lockstep_err and returns to RUN
//   cN_req / cN_addr       fetch request and address of core N (held until grant)
//   cN_gnt                 combinational request accept
//   cN_rvalid / cN_rdata   instruction response, one cycle after the grant
//   mem_addr / mem_rdata   instruction memory address out, instruction in
//   lockstep_err           sticky divergence/timeout flag
module imem_lockstep_arbiter #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              lockstep_en,
   input  logic              err_clr,
   input  logic              c0_req,
   input  logic [ADDR_W-1:0] c0_addr,
   output logic              c0_gnt,
   output logic              c0_rvalid,
   output logic [DATA_W-1:0] c0_rdata,
   input  logic              c1_req,
   input  logic [ADDR_W-1:0] c1_addr,
   output logic              c1_gnt,
   output logic              c1_rvalid,
   output logic [DATA_W-1:0] c1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lockstep_err
);

   localparam int unsigned CNT_W = 8;
   localparam logic [0:0]  ST_RUN = 1'b0;
   localparam logic [0:0]  ST_ERR = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic              c0_rvalid_q, c1_rvalid_q;

   logic              gnt0, gnt1;
   logic              err_cond;
   logic              both_req, one_req, addr_eq;
   logic [CNT_W:0]    wait_inc;

   // Next-state, grant and memory address selection
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      wait_cnt_d  = wait_cnt_q;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      err_cond    = 1'b0;
      both_req    = c0_req & c1_req;
      one_req     = c0_req ^ c1_req;
      addr_eq     = (c0_addr == c1_addr);
      // one bit wider so a saturated count cannot wrap in the compare
      wait_inc    = {1'b0, wait_cnt_q} + (CNT_W+1)'(1);

      if (lockstep_en) begin
         if (both_req && addr_eq) begin
            wait_cnt_d = '0;
            if (state_q == ST_RUN) begin
               gnt0 = 1'b1;
               gnt1 = 1'b1;
            end
         end else if (both_req) begin
            wait_cnt_d = '0;
            err_cond   = 1'b1;
         end else if (one_req) begin
            if (wait_cnt_q < CNT_W'(TIMEOUT)) begin
               wait_cnt_d = wait_inc[CNT_W-1:0];
            end
            if (wait_inc >= (CNT_W+1)'(TIMEOUT)) begin
               err_cond = 1'b1;
            end
         end else begin
            wait_cnt_d = '0;
         end
      end else begin
         // the wait counter only runs in lockstep, so a mode change always
         // starts lockstep with a fresh count
         wait_cnt_d = '0;
         if (state_q == ST_RUN) begin
            if (both_req) begin
               gnt0 = ~rr_ptr_q;
               gnt1 = rr_ptr_q;
            end else begin
               gnt0 = c0_req;
               gnt1 = c1_req;
            end
         end
         if (gnt0) begin
            rr_ptr_d = 1'b1;
         end else if (gnt1) begin
            rr_ptr_d = 1'b0;
         end
      end

      // no grant may escape while reset is held
      gnt0 = gnt0 & reset_n;
      gnt1 = gnt1 & reset_n;

      if (gnt0) begin
         mem_addr = c0_addr;
      end else if (gnt1) begin
         mem_addr = c1_addr;
      end else begin
         mem_addr = last_addr_q;
      end
      last_addr_d = mem_addr;

      case (state_q)
         ST_RUN: begin
            if (err_cond) begin
               state_d = ST_ERR;
            end
         end
         ST_ERR: begin
            // a fresh error in the clear cycle keeps the flag set
            if (!err_cond && err_clr) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         rr_ptr_q    <= 1'b0;
         wait_cnt_q  <= '0;
         last_addr_q <= '0;
         c0_rvalid_q <= 1'b0;
         c1_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         wait_cnt_q  <= wait_cnt_d;
         last_addr_q <= last_addr_d;
         c0_rvalid_q <= gnt0;
         c1_rvalid_q <= gnt1;
      end
   end

   assign c0_gnt       = gnt0;
   assign c1_gnt       = gnt1;
   assign c0_rvalid    = c0_rvalid_q;
   assign c1_rvalid    = c1_rvalid_q;
   assign c0_rdata     = c0_rvalid_q ? mem_rdata : '0;
   assign c1_rdata     = c1_rvalid_q ? mem_rdata : '0;
   assign lockstep_err = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_lockstep_arbiter.sv
// Testbench for imem_lockstep_arbiter: directed scenarios plus randomized
// traffic, compared cycle by cycle against a behavioural model.
module tb_imem_lockstep_arbiter;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 15;
   localparam int unsigned VW = 5 + AW + 2*DW;

   logic          clock, reset_n, lockstep_en, err_clr;
   logic          c0_req, c1_req, c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
   logic [AW-1:0] c0_addr, c1_addr, mem_addr;
   logic [DW-1:0] c0_rdata, c1_rdata, mem_rdata;
   logic          lockstep_err;

   imem_lockstep_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset_n(reset_n), .lockstep_en(lockstep_en), .err_clr(err_clr),
      .c0_req(c0_req), .c0_addr(c0_addr), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
      .c1_req(c1_req), .c1_addr(c1_addr), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .lockstep_err(lockstep_err)
   );

   // single-port memory with registered read
   logic [DW-1:0] mem [256];
   always @(posedge clock) mem_rdata <= mem[mem_addr];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit          m_err, m_rr, m_pv0, m_pv1;
   int          m_wait;
   logic [AW-1:0] m_last, m_pa;
   // inputs of the current cycle and expectations derived from them
   bit          i_r0, i_r1, i_ls, i_clr;
   bit          e_g0, e_g1, e_errc;
   logic [AW-1:0] e_maddr;
   logic [VW-1:0] exp_v;

   function automatic logic [VW-1:0] observed();
      return {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, lockstep_err, mem_addr, c0_rdata, c1_rdata};
   endfunction

   task automatic model_reset();
      m_err = 0; m_rr = 0; m_pv0 = 0; m_pv1 = 0; m_wait = 0; m_last = '0; m_pa = '0;
   endtask

   // drive one cycle of inputs and work out what the DUT should show
   task automatic apply(input bit r0, input logic [AW-1:0] a0, input bit r1,
                        input logic [AW-1:0] a1, input bit ls, input bit clr);
      @(negedge clock);
      c0_req = r0; c0_addr = a0; c1_req = r1; c1_addr = a1;
      lockstep_en = ls; err_clr = clr;
      i_r0 = r0; i_r1 = r1; i_ls = ls; i_clr = clr;
      #1;
      e_g0 = 0; e_g1 = 0; e_errc = 0;
      if (ls) begin
         if (r0 && r1 && a0 == a1) begin
            e_g0 = !m_err;
            e_g1 = !m_err;
         end
         e_errc = (r0 && r1 && a0 != a1) || ((r0 != r1) && (m_wait + 1 >= int'(TO)));
      end else if (!m_err) begin
         if (r0 && r1) begin
            e_g0 = !m_rr;
            e_g1 = m_rr;
         end else begin
            e_g0 = r0;
            e_g1 = r1;
         end
      end
      e_maddr = e_g0 ? a0 : (e_g1 ? a1 : m_last);
      exp_v = {e_g0, e_g1, m_pv0, m_pv1, m_err, e_maddr,
               m_pv0 ? mem[m_pa] : 32'h0, m_pv1 ? mem[m_pa] : 32'h0};
   endtask

   // clock edge: move the model to its next state
   task automatic advance();
      @(posedge clock);
      m_pv0 = e_g0; m_pv1 = e_g1;
      m_pa = e_maddr; m_last = e_maddr;
      if (!i_ls) begin
         if (e_g0) m_rr = 1;
         else if (e_g1) m_rr = 0;
      end
      if (!i_ls) m_wait = 0;
      else if (i_r0 != i_r1) m_wait = (m_wait < int'(TO)) ? m_wait + 1 : m_wait;
      else m_wait = 0;
      if (e_errc) m_err = 1;
      else if (i_clr) m_err = 0;
   endtask

   task automatic release_reset();
      c0_req = 0; c1_req = 0; err_clr = 0;
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; lockstep_en = 1'b0; err_clr = 1'b0;
      c0_req = 1; c1_req = 1; c0_addr = 8'h10; c1_addr = 8'h10;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (observed() !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=0", observed());
      end
      release_reset();
   endtask

   task automatic test_split();
      for (int i = 0; i < 6; i++) begin
         apply(1, 8'h10, 1, 8'h20, 0, 0);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL split_rr cyc=%0d got=%h want=%h", i, observed(), exp_v);
         end
         checks++;
         if ({c0_gnt, c1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL split_alternate cyc=%0d got=%b", i, {c0_gnt, c1_gnt});
         end
         advance();
      end
      apply(0, 8'h00, 0, 8'h00, 0, 0);
      checks++;
      if (observed() !== exp_v || c1_rdata !== mem[8'h20] || mem_addr !== 8'h20) begin
         errors++;
         $display("FAIL split_tail got=%h want=%h", observed(), exp_v);
      end
      advance();
   endtask

   task automatic test_lockstep_match();
      apply(1, 8'h05, 1, 8'h05, 1, 0);
      checks++;
      if (observed() !== exp_v || {c0_gnt, c1_gnt} !== 2'b11) begin
         errors++;
         $display("FAIL ls_match_gnt got=%h want=%h", observed(), exp_v);
      end
      advance();
      apply(0, 8'h00, 0, 8'h00, 1, 0);
      checks++;
      if (observed() !== exp_v || c0_rdata !== mem[8'h05] || c1_rdata !== mem[8'h05]) begin
         errors++;
         $display("FAIL ls_match_data got=%h want=%h", observed(), exp_v);
      end
      advance();
   endtask

   task automatic test_divergence();
      // divergence, blocked matching request, clear colliding with a new
      // divergence, clean clear, then a normal grant
      bit          seq_r [5]  = '{1, 1, 1, 0, 1};
      logic [AW-1:0] seq_b [5] = '{8'h06, 8'h05, 8'h06, 8'h00, 8'h05};
      bit          seq_c [5]  = '{0, 0, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         apply(seq_r[i], 8'h05, seq_r[i], seq_b[i], 1, seq_c[i]);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL diverge step=%0d got=%h want=%h", i, observed(), exp_v);
         end
         advance();
      end
      apply(0, 8'h00, 0, 8'h00, 1, 0);
      checks++;
      if (lockstep_err !== 1'b0 || c0_rvalid !== 1'b1 || observed() !== exp_v) begin
         errors++;
         $display("FAIL diverge_recover got=%h want=%h", observed(), exp_v);
      end
      advance();
   endtask

   task automatic test_timeout();
      for (int i = 0; i < int'(TO); i++) begin
         apply(1, 8'h07, 0, 8'h00, 1, 0);
         checks++;
         if (observed() !== exp_v || lockstep_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait cyc=%0d got=%h want=%h", i, observed(), exp_v);
         end
         advance();
      end
      apply(0, 8'h00, 0, 8'h00, 1, 1);
      checks++;
      if (lockstep_err !== 1'b1 || observed() !== exp_v) begin
         errors++;
         $display("FAIL timeout_flag got=%h want=%h", observed(), exp_v);
      end
      advance();
      // partner arrives on the 14th waiting cycle
      for (int i = 0; i < int'(TO) - 2; i++) begin
         apply(1, 8'h07, 0, 8'h00, 1, 0);
         advance();
      end
      apply(1, 8'h07, 1, 8'h07, 1, 0);
      checks++;
      if ({c0_gnt, c1_gnt, lockstep_err} !== 3'b110 || observed() !== exp_v) begin
         errors++;
         $display("FAIL timeout_partner got=%h want=%h", observed(), exp_v);
      end
      advance();
      apply(0, 8'h00, 0, 8'h00, 1, 0);
      advance();
   endtask

   task automatic test_reset_mid();
      apply(1, 8'h33, 0, 8'h00, 0, 0);
      advance();
      #1;
      checks++;
      if (c0_rvalid !== 1'b1 || c0_rdata !== mem[8'h33]) begin
         errors++;
         $display("FAIL midrst_pre rvalid=%b rdata=%h want 1/%h", c0_rvalid, c0_rdata, mem[8'h33]);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (c0_rvalid !== 1'b0 || c0_rdata !== '0 || c0_gnt !== 1'b0 || mem_addr !== '0) begin
         errors++;
         $display("FAIL midrst_drop rvalid=%b rdata=%h gnt=%b addr=%h want 0", c0_rvalid, c0_rdata, c0_gnt, mem_addr);
      end
      release_reset();
      apply(1, 8'h33, 1, 8'h44, 0, 0);
      checks++;
      if (observed() !== exp_v || {c0_gnt, c1_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL midrst_after got=%h want=%h", observed(), exp_v);
      end
      advance();
   endtask

   task automatic test_random();
      bit ls = 0;
      for (int i = 0; i < 600; i++) begin
         bit r0, r1, clr;
         logic [AW-1:0] a0, a1;
         if (i % 50 == 0) ls = ($urandom_range(0, 1) == 1);
         r0  = ($urandom_range(0, 7) != 0);
         r1  = (i % 200 < 100) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
         a0  = AW'($urandom_range(0, 3));
         a1  = (ls && $urandom_range(0, 15) != 0) ? a0 : AW'($urandom_range(0, 3));
         clr = ($urandom_range(0, 5) == 0);
         apply(r0, a0, r1, a1, ls, clr);
         checks++;
         if (observed() !== exp_v) begin
            errors++;
            $display("FAIL random cyc=%0d ls=%0b got=%h want=%h", i, ls, observed(), exp_v);
         end
         advance();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      model_reset();
      test_reset();
      test_split();
      test_lockstep_match();
      test_divergence();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
